// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The slave side is the controller; the master side drives opcode/flags and observes controls.
interface mc_ctrl_if;
    logic [5:0] i_Op;
    logic [5:0] i_Funct;
    logic       i_Zero;
    logic       i_MemReady;
    logic       o_PCen;
    logic       o_IorD;
    logic [1:0] o_PCsrc;
    logic       o_IRwrite;
    logic       o_MemWrite;
    logic       o_RegWrite;
    logic       o_RegDst;
    logic       o_MemtoReg;
    logic       o_ALUsrcA;
    logic [1:0] o_ALUsrcB;
    logic [2:0] o_ALUcontrol;
    logic [3:0] o_State;
    logic       o_Illegal;

    modport slave (
        input  i_Op, i_Funct, i_Zero, i_MemReady,
        output o_PCen, o_IorD, o_PCsrc, o_IRwrite, o_MemWrite, o_RegWrite,
               o_RegDst, o_MemtoReg, o_ALUsrcA, o_ALUsrcB, o_ALUcontrol,
               o_State, o_Illegal
    );

    modport master (
        output i_Op, i_Funct, i_Zero, i_MemReady,
        input  o_PCen, o_IorD, o_PCsrc, o_IRwrite, o_MemWrite, o_RegWrite,
               o_RegDst, o_MemtoReg, o_ALUsrcA, o_ALUsrcB, o_ALUcontrol,
               o_State, o_Illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ready stalls and illegal-instruction flagging.
module mc_ctrl (
    input  logic       i_clk,
    input  logic       i_reset,
    mc_ctrl_if.slave   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_cur;
    state_t     w_next;
    logic       w_PCen, w_IorD, w_IRwrite, w_MemWrite, w_RegWrite;
    logic       w_RegDst, w_MemtoReg, w_ALUsrcA, w_Illegal;
    logic [1:0] w_PCsrc, w_ALUsrcB;
    logic [2:0] w_ALUcontrol;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_FETCH;
        else         r_state <= w_next;
    end

    always_comb begin
        // Reset is synchronous, so outputs are decoded as FETCH while it is held
        w_cur        = i_reset ? S_FETCH : r_state;
        w_next       = S_FETCH;
        w_PCen       = 1'b0;
        w_IorD       = 1'b0;
        w_PCsrc      = 2'b00;
        w_IRwrite    = 1'b0;
        w_MemWrite   = 1'b0;
        w_RegWrite   = 1'b0;
        w_RegDst     = 1'b0;
        w_MemtoReg   = 1'b0;
        w_ALUsrcA    = 1'b0;
        w_ALUsrcB    = 2'b00;
        w_ALUcontrol = 3'b000;
        w_Illegal    = 1'b0;
        case (w_cur)
            S_FETCH: begin
                w_ALUsrcB    = 2'b01;
                w_ALUcontrol = 3'b010;
                w_IRwrite    = bus.i_MemReady;
                w_PCen       = bus.i_MemReady;
                w_next       = bus.i_MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_ALUsrcB    = 2'b11;
                w_ALUcontrol = 3'b010;
                case (bus.i_Op)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_EXECUTE;
                    6'b000100:            w_next = S_BRANCH;
                    6'b001000:            w_next = S_ADDIEXEC;
                    6'b000010:            w_next = S_JUMP;
                    default:              w_Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_ALUsrcA    = 1'b1;
                w_ALUsrcB    = 2'b10;
                w_ALUcontrol = 3'b010;
                w_next       = (bus.i_Op == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_IorD = 1'b1;
                w_next = bus.i_MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_MemtoReg = 1'b1;
                w_RegWrite = 1'b1;
            end
            S_MEMWR: begin
                w_IorD     = 1'b1;
                w_MemWrite = bus.i_MemReady;
                w_next     = bus.i_MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                w_ALUsrcA = 1'b1;
                w_next    = S_ALUWB;
                case (bus.i_Funct)
                    6'b100000: w_ALUcontrol = 3'b010;
                    6'b100010: w_ALUcontrol = 3'b110;
                    6'b100100: w_ALUcontrol = 3'b000;
                    6'b100101: w_ALUcontrol = 3'b001;
                    6'b101010: w_ALUcontrol = 3'b111;
                    default: begin
                        w_ALUcontrol = 3'b010;
                        w_Illegal    = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                w_RegDst   = 1'b1;
                w_RegWrite = 1'b1;
            end
            S_BRANCH: begin
                w_ALUsrcA    = 1'b1;
                w_ALUcontrol = 3'b110;
                w_PCsrc      = 2'b01;
                w_PCen       = bus.i_Zero;
            end
            S_ADDIEXEC: begin
                w_ALUsrcA    = 1'b1;
                w_ALUsrcB    = 2'b10;
                w_ALUcontrol = 3'b010;
                w_next       = S_ADDIWB;
            end
            S_ADDIWB: w_RegWrite = 1'b1;
            S_JUMP: begin
                w_PCsrc = 2'b10;
                w_PCen  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (i_reset) begin
            w_PCen     = 1'b0;
            w_IRwrite  = 1'b0;
            w_MemWrite = 1'b0;
            w_RegWrite = 1'b0;
            w_Illegal  = 1'b0;
        end
    end

    assign bus.o_PCen       = w_PCen;
    assign bus.o_IorD       = w_IorD;
    assign bus.o_PCsrc      = w_PCsrc;
    assign bus.o_IRwrite    = w_IRwrite;
    assign bus.o_MemWrite   = w_MemWrite;
    assign bus.o_RegWrite   = w_RegWrite;
    assign bus.o_RegDst     = w_RegDst;
    assign bus.o_MemtoReg   = w_MemtoReg;
    assign bus.o_ALUsrcA    = w_ALUsrcA;
    assign bus.o_ALUsrcB    = w_ALUsrcB;
    assign bus.o_ALUcontrol = w_ALUcontrol;
    assign bus.o_State      = w_cur;
    assign bus.o_Illegal    = w_Illegal;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle vector table plus stall/funct sequences,
// expected values queued at drive time and compared on the falling edge.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst;
    mc_ctrl_if bus ();

    mc_ctrl dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_SUB = 6'b100010, F_BAD = 6'b111111;

    // {PCen, IorD, PCsrc[1:0], IRwrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUsrcA, ALUsrcB[1:0], ALUcontrol[2:0], Illegal}
    localparam logic [15:0] FW      = 16'b0_0_00_0_0_0_0_0_0_01_010_0;
    localparam logic [15:0] FR      = 16'b1_0_00_1_0_0_0_0_0_01_010_0;
    localparam logic [15:0] DEC     = 16'b0_0_00_0_0_0_0_0_0_11_010_0;
    localparam logic [15:0] DEC_ILL = 16'b0_0_00_0_0_0_0_0_0_11_010_1;
    localparam logic [15:0] MADR    = 16'b0_0_00_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] MRD     = 16'b0_1_00_0_0_0_0_0_0_00_000_0;
    localparam logic [15:0] MWB     = 16'b0_0_00_0_0_1_0_1_0_00_000_0;
    localparam logic [15:0] MWR_W   = 16'b0_1_00_0_0_0_0_0_0_00_000_0;
    localparam logic [15:0] MWR_R   = 16'b0_1_00_0_1_0_0_0_0_00_000_0;
    localparam logic [15:0] EX_SUB  = 16'b0_0_00_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] EX_ILL  = 16'b0_0_00_0_0_0_0_0_1_00_010_1;
    localparam logic [15:0] AWB     = 16'b0_0_00_0_0_1_1_0_0_00_000_0;
    localparam logic [15:0] BRZ1    = 16'b1_0_01_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] BRZ0    = 16'b0_0_01_0_0_0_0_0_1_00_110_0;
    localparam logic [15:0] AEX     = 16'b0_0_00_0_0_0_0_0_1_10_010_0;
    localparam logic [15:0] AIWB    = 16'b0_0_00_0_0_1_0_0_0_00_000_0;
    localparam logic [15:0] JUMP_O  = 16'b1_0_10_0_0_0_0_0_0_00_000_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] outs;
        string       tag;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] outs;
        string       tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    function automatic vec_t v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr, input logic [3:0] st,
                               input logic [15:0] o, input string tag);
        vec_t x;
        x.rst = r; x.op = op; x.fn = fn; x.z = z; x.mr = mr;
        x.st = st; x.outs = o; x.tag = tag;
        return x;
    endfunction

    function automatic logic [15:0] ex_o(input logic [2:0] c);
        return {10'b0000000001, 2'b00, c, 1'b0};
    endfunction

    task automatic step(input vec_t x);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = x.rst;
        bus.i_Op       = x.op;
        bus.i_Funct    = x.fn;
        bus.i_Zero     = x.z;
        bus.i_MemReady = x.mr;
        e.st = x.st; e.outs = x.outs; e.tag = x.tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] got;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            got = {bus.o_PCen, bus.o_IorD, bus.o_PCsrc, bus.o_IRwrite, bus.o_MemWrite,
                   bus.o_RegWrite, bus.o_RegDst, bus.o_MemtoReg, bus.o_ALUsrcA,
                   bus.o_ALUsrcB, bus.o_ALUcontrol, bus.o_Illegal};
            n_checks++;
            if (bus.o_State !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d want %0d", e.tag, bus.o_State, e.st);
            end
            n_checks++;
            if (got !== e.outs) begin
                n_fail++;
                $display("FAIL %s outs: got %b want %b", e.tag, got, e.outs);
            end
        end
    end

    initial begin
        logic [5:0] fns[5];
        logic [2:0] ctls[5];
        rst = 1'b1; bus.i_Op = LW; bus.i_Funct = '0; bus.i_Zero = 1'b0; bus.i_MemReady = 1'b0;

        tbl.push_back(v(1, LW, 0, 0, 1, 0, FW, "rst_mr1"));
        tbl.push_back(v(1, LW, 0, 0, 0, 0, FW, "rst_mr0"));
        tbl.push_back(v(0, LW, 0, 0, 1, 0, FR, "lw_fetch"));
        tbl.push_back(v(0, LW, 0, 0, 1, 1, DEC, "lw_dec"));
        tbl.push_back(v(0, LW, 0, 0, 1, 2, MADR, "lw_madr"));
        tbl.push_back(v(0, LW, 0, 0, 1, 3, MRD, "lw_mrd"));
        tbl.push_back(v(0, LW, 0, 0, 1, 4, MWB, "lw_mwb"));
        tbl.push_back(v(0, SW, 0, 0, 1, 0, FR, "sw_fetch"));
        tbl.push_back(v(0, SW, 0, 0, 1, 1, DEC, "sw_dec"));
        tbl.push_back(v(0, SW, 0, 0, 0, 2, MADR, "sw_madr"));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, SW, 0, 0, 0, 5, MWR_W, "sw_wait"));
        tbl.push_back(v(0, SW, 0, 0, 1, 5, MWR_R, "sw_write"));
        tbl.push_back(v(0, RT, F_SUB, 0, 0, 0, FW, "fetch_stall1"));
        tbl.push_back(v(0, RT, F_SUB, 0, 0, 0, FW, "fetch_stall2"));
        tbl.push_back(v(0, RT, F_SUB, 0, 1, 0, FR, "sub_fetch"));
        tbl.push_back(v(0, RT, F_SUB, 0, 0, 1, DEC, "sub_dec"));
        tbl.push_back(v(0, RT, F_SUB, 0, 0, 6, EX_SUB, "sub_exec"));
        tbl.push_back(v(0, RT, F_SUB, 0, 0, 7, AWB, "sub_wb"));
        tbl.push_back(v(0, RT, F_BAD, 0, 1, 0, FR, "badf_fetch"));
        tbl.push_back(v(0, RT, F_BAD, 0, 1, 1, DEC, "badf_dec"));
        tbl.push_back(v(0, RT, F_BAD, 0, 1, 6, EX_ILL, "badf_exec"));
        tbl.push_back(v(0, RT, F_BAD, 0, 0, 0, FW, "badf_after"));
        tbl.push_back(v(0, BEQ, 0, 1, 1, 0, FR, "beq1_fetch"));
        tbl.push_back(v(0, BEQ, 0, 1, 1, 1, DEC, "beq1_dec"));
        tbl.push_back(v(0, BEQ, 0, 1, 0, 8, BRZ1, "beq1_br"));
        tbl.push_back(v(0, BEQ, 0, 0, 1, 0, FR, "beq0_fetch"));
        tbl.push_back(v(0, BEQ, 0, 0, 1, 1, DEC, "beq0_dec"));
        tbl.push_back(v(0, BEQ, 0, 0, 1, 8, BRZ0, "beq0_br"));
        tbl.push_back(v(0, ADDI, 0, 0, 1, 0, FR, "addi_fetch"));
        tbl.push_back(v(0, ADDI, 0, 0, 0, 1, DEC, "addi_dec"));
        tbl.push_back(v(0, ADDI, 0, 0, 0, 9, AEX, "addi_exec"));
        tbl.push_back(v(0, ADDI, 0, 0, 0, 10, AIWB, "addi_wb"));
        tbl.push_back(v(0, JMP, 0, 0, 1, 0, FR, "j_fetch"));
        tbl.push_back(v(0, JMP, 0, 0, 1, 1, DEC, "j_dec"));
        tbl.push_back(v(0, JMP, 0, 0, 0, 11, JUMP_O, "j_jump"));
        tbl.push_back(v(0, BAD, 0, 0, 1, 0, FR, "badop_fetch"));
        tbl.push_back(v(0, BAD, 0, 0, 1, 1, DEC_ILL, "badop_dec"));
        tbl.push_back(v(0, BAD, 0, 0, 0, 0, FW, "badop_after"));
        tbl.push_back(v(0, LW, 0, 0, 1, 0, FR, "rstmid_fetch"));
        tbl.push_back(v(0, LW, 0, 0, 1, 1, DEC, "rstmid_dec"));
        tbl.push_back(v(0, LW, 0, 0, 1, 2, MADR, "rstmid_madr"));
        tbl.push_back(v(0, LW, 0, 0, 0, 3, MRD, "rstmid_wait"));
        tbl.push_back(v(1, LW, 0, 0, 1, 0, FW, "rstmid_rst"));
        tbl.push_back(v(0, LW, 0, 0, 0, 0, FW, "rstmid_after"));

        foreach (tbl[i]) step(tbl[i]);

        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ctls = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            step(v(0, RT, fns[i], 0, 1, 0, FR, "rt_fetch"));
            step(v(0, RT, fns[i], 0, 1, 1, DEC, "rt_dec"));
            step(v(0, RT, fns[i], 0, 1, 6, ex_o(ctls[i]), "rt_exec"));
            step(v(0, RT, fns[i], 0, 1, 7, AWB, "rt_wb"));
        end

        for (int k = 1; k <= 3; k++) begin
            step(v(0, LW, 0, 0, 1, 0, FR, "lwk_fetch"));
            step(v(0, LW, 0, 0, 1, 1, DEC, "lwk_dec"));
            step(v(0, LW, 0, 0, 1, 2, MADR, "lwk_madr"));
            for (int j = 0; j < k; j++) step(v(0, LW, 0, 0, 0, 3, MRD, "lwk_wait"));
            step(v(0, LW, 0, 0, 1, 3, MRD, "lwk_rd"));
            step(v(0, LW, 0, 0, 1, 4, MWB, "lwk_wb"));
        end

        step(v(0, SW, 0, 0, 1, 0, FR, "sw0_fetch"));
        step(v(0, SW, 0, 0, 1, 1, DEC, "sw0_dec"));
        step(v(0, SW, 0, 0, 1, 2, MADR, "sw0_madr"));
        step(v(0, SW, 0, 0, 1, 5, MWR_R, "sw0_write"));
        step(v(0, SW, 0, 0, 0, 0, FW, "sw0_after"));

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
